fetch_ifid_stage: RTL and testbench
===================================

Name: fetch_ifid_stage

Overview:
- Instruction-fetch front end: owns the PC register, drives the address into the word-addressed instruction memory (combinational read), and captures the returned instruction into the IF/ID pipeline latch.
- Sits between the hazard/branch logic (EX/MEM PCSrc, hazard unit) and the decode stage.
- Supports stall, flush and branch redirect, with a small FSM that inserts bubbles.

Parameters:
- MEM_WORDS, 128, instruction memory depth in 32-bit words; power of two.
- RESET_PC, 0, PC value loaded on reset; must be < MEM_WORDS.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- instr_in  input  32  instruction word returned by memory for pc_addr, valid in the same cycle.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  kill IF/ID contents.
- branch_taken  input  1  redirect request (PCSrc).
- branch_target  input  32  word address of redirect target.
- pc_addr  output  32  current PC, to memory address input.
- ifid_instr  output  32  latched instruction.
- ifid_npc  output  32  latched PC+1 of that instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- fetch_state  output  2  FSM state, for debug.
- fetch_cnt  output  32  performance counter; see Optional Feature.
- bubble_cnt  output  32  performance counter; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at posedge) loads:
  - pc_q=RESET_PC, ifid_instr=0, ifid_npc=0, ifid_valid=0.
  - state=BOOT, counters=0.
  - Reset takes effect mid-operation with no other input honoured that edge.
- pc_addr = pc_q, zero-extended. AW = log2(MEM_WORDS).
- Wrap arithmetic:
  - Increment is (pc_q+1) mod MEM_WORDS.
  - branch_target is truncated to its low AW bits (target 0x85 with MEM_WORDS=128 gives 0x05).
- FSM states: BOOT=0, RUN=1, HOLD=2, REDIR=3.
- BOOT: one cycle after reset. PC held, ifid_valid<=0. Goes to RUN; all requests are ignored in this cycle.
- RUN/HOLD: per-edge priority branch_taken > flush > stall > advance.
  - branch_taken: pc_q<=target, ifid_instr<=0, ifid_valid<=0, go to REDIR.
  - flush: ifid_instr<=0, ifid_valid<=0, pc_q held, go to RUN.
  - stall: PC and all IF/ID outputs held unchanged, go to HOLD.
  - advance: ifid_instr<=instr_in, ifid_npc<=pc_q+1 (wrapped), ifid_valid<=1, pc_q<=pc_q+1 (wrapped), go to RUN.
- REDIR: exactly one settle cycle, which yields two bubbles per taken branch.
  - branch_taken again: load the new target, stay in REDIR.
  - Otherwise: pc_q held, ifid_valid<=0, go to RUN.
  - stall and flush are ignored because IF/ID is already a bubble.
- A bubble is always ifid_instr=0 (NOP); ifid_npc is unchanged.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_cnt increments on every edge that writes ifid_valid<=1.
  - bubble_cnt increments on every non-reset edge that writes ifid_valid<=0, including BOOT, REDIR, branch and flush; stall-hold edges do not count.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both ports remain and are tied to 0, so the interface is identical either way.

Decomposition:
- Package fetch_pkg holds:
  - state encoding constants (S_BOOT, S_RUN, S_HOLD, S_REDIR);
  - NOP_INSTR=32'h0;
  - width of fetch_state.
- One sub-module, pc_wrap_incr: combinational (pc+1) mod MEM_WORDS, parameterised by MEM_WORDS. It is instantiated once and its output is shared by the pc_q and ifid_npc paths.

Test Plan:
- Memory preloaded MEM[0..9]=A00000AA,10000011,...,90000099; rst_n low 2 edges, then high.
  - First edge: BOOT, valid=0.
  - Next edge: ifid_instr=A00000AA, ifid_npc=1, valid=1, pc_addr=1.
  - Next edge: 10000011 with npc=2.
- After 20000022 is captured (pc_addr=3), assert stall for 3 edges.
  - IF/ID holds 20000022/3, pc_addr stays 3, fetch_state=HOLD.
  - On release, the next edge captures 30000033, npc=4.
- At pc_addr=4, pulse branch_taken with target=8.
  - Next edge: pc_addr=8, valid=0, state REDIR.
  - Next edge: valid=0, state RUN.
  - Next edge: ifid_instr=80000088, npc=9.
  - With FETCH_PERF_CNT_EN, bubble_cnt rises by 2.
- Run to pc_addr=127, then advance: ifid_npc=0, pc_addr=0. Then branch_target=0x85 gives pc_addr=5.
- branch_taken, flush and stall asserted on the same edge with target=2: redirect wins (pc_addr=2, REDIR, valid=0).
- rst_n low during HOLD at pc_addr=6: next edge pc_addr=RESET_PC, all IF/ID outputs 0, state BOOT, counters 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch / IF/ID stage.
package fetch_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_REDIR = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_wrap_incr.sv
// Combinational PC increment that wraps modulo the instruction memory depth.
module pc_wrap_incr #(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic [$clog2(MEM_WORDS)-1:0] pc_i,
  output logic [$clog2(MEM_WORDS)-1:0] pc_inc_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  // MEM_WORDS is a power of two, so natural AW-bit overflow is the wrap.
  assign pc_inc_o = pc_i + AW'(1);

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch front end: PC register, IF/ID latch and bubble-inserting FSM.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ifid_stage
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 128,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_in,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        pc_addr,
  output logic [31:0]        ifid_instr,
  output logic [31:0]        ifid_npc,
  output logic               ifid_valid,
  output logic [STATE_W-1:0] fetch_state,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] ResetPc = AW'(RESET_PC);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic [AW-1:0] npc_q, npc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          fetch_ev, bubble_ev;
  logic [AW-1:0] target;
  logic          unused_target_hi;

  assign target           = branch_target[AW-1:0];
  assign unused_target_hi = ^branch_target[31:AW];

  pc_wrap_incr #(
    .MEM_WORDS(MEM_WORDS)
  ) u_pc_incr (
    .pc_i    (pc_q),
    .pc_inc_o(pc_inc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    fetch_ev  = 1'b0;
    bubble_ev = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        instr_d   = NOP_INSTR;
        valid_d   = 1'b0;
        bubble_ev = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN, S_HOLD: begin
        if (branch_taken) begin
          pc_d      = target;
          instr_d   = NOP_INSTR;
          valid_d   = 1'b0;
          bubble_ev = 1'b1;
          state_d   = S_REDIR;
        end else if (flush) begin
          instr_d   = NOP_INSTR;
          valid_d   = 1'b0;
          bubble_ev = 1'b1;
          state_d   = S_RUN;
        end else if (stall) begin
          state_d   = S_HOLD;
        end else begin
          instr_d   = instr_in;
          npc_d     = pc_inc;
          valid_d   = 1'b1;
          pc_d      = pc_inc;
          fetch_ev  = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_REDIR: begin
        // IF/ID is already a bubble here, so stall and flush have nothing to act on.
        instr_d   = NOP_INSTR;
        valid_d   = 1'b0;
        bubble_ev = 1'b1;
        if (branch_taken) begin
          pc_d    = target;
          state_d = S_REDIR;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= ResetPc;
      npc_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_addr     = 32'(pc_q);
  assign ifid_instr  = instr_q;
  assign ifid_npc    = 32'(npc_q);
  assign ifid_valid  = valid_q;
  assign fetch_state = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (fetch_ev && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (bubble_ev && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_ev;
  assign unused_ev  = fetch_ev ^ bubble_ev;
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Table-driven self-checking bench for fetch_ifid_stage with a scoreboard queue.
module tb_fetch_ifid_stage;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [1:0]  st;
    int          df;
    int          db;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [1:0]  st;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc_addr, ifid_instr, ifid_npc, fetch_cnt, bubble_cnt;
  logic        ifid_valid;
  logic [1:0]  fetch_state;

  logic [31:0] mem [128];
  vec_t        prog [$];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_fcnt = '0;
  logic [31:0] m_bcnt = '0;

  always #5 clk = ~clk;

  assign instr_in = mem[pc_addr[6:0]];

  fetch_ifid_stage #(
    .MEM_WORDS(128),
    .RESET_PC (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_in     (instr_in),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc_addr      (pc_addr),
    .ifid_instr   (ifid_instr),
    .ifid_npc     (ifid_npc),
    .ifid_valid   (ifid_valid),
    .fetch_state  (fetch_state),
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  function automatic logic [31:0] mem_word(int k);
    if (k == 0) return 32'hA000_00AA;
    if (k < 10) return 32'h1000_0011 * k;
    return 32'hC000_0000 + k;
  endfunction

  function automatic vec_t mk(logic r, logic s, logic f, logic b, logic [31:0] t,
                              logic [31:0] pc, logic [31:0] ins, logic [31:0] npc,
                              logic v, logic [1:0] st, int df, int db);
    vec_t x;
    x.rst_n = r; x.stall = s; x.flush = f; x.br = b; x.tgt = t;
    x.pc = pc; x.instr = ins; x.npc = npc; x.valid = v; x.st = st; x.df = df; x.db = db;
    return x;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = mem_word(k);

    // Reset, boot, first fetches
    prog.push_back(mk(0,0,0,0,0,  0,0,0,0,0, 0,0));
    prog.push_back(mk(0,0,0,0,0,  0,0,0,0,0, 0,0));
    prog.push_back(mk(1,0,0,0,0,  0,0,0,0,1, 0,1));
    prog.push_back(mk(1,0,0,0,0,  1,32'hA000_00AA,1,1,1, 1,0));
    prog.push_back(mk(1,0,0,0,0,  2,32'h1000_0011,2,1,1, 1,0));
    prog.push_back(mk(1,0,0,0,0,  3,32'h2000_0022,3,1,1, 1,0));
    // Stall three edges, then release
    for (int i = 0; i < 3; i++) prog.push_back(mk(1,1,0,0,0, 3,32'h2000_0022,3,1,2, 0,0));
    prog.push_back(mk(1,0,0,0,0,  4,32'h3000_0033,4,1,1, 1,0));
    // Taken branch to 8: two bubbles
    prog.push_back(mk(1,0,0,1,8,  8,0,4,0,3, 0,1));
    prog.push_back(mk(1,0,0,0,0,  8,0,4,0,1, 0,1));
    prog.push_back(mk(1,0,0,0,0,  9,32'h8000_0088,9,1,1, 1,0));
    // Flush keeps PC and npc
    prog.push_back(mk(1,0,1,0,0,  9,0,9,0,1, 0,1));
    prog.push_back(mk(1,0,0,0,0, 10,32'h9000_0099,10,1,1, 1,0));
    // Back-to-back branches: second one re-targets while in REDIR
    prog.push_back(mk(1,0,0,1,20, 20,0,10,0,3, 0,1));
    prog.push_back(mk(1,0,0,1,30, 30,0,10,0,3, 0,1));
    prog.push_back(mk(1,0,0,0,0,  30,0,10,0,1, 0,1));
    prog.push_back(mk(1,0,0,0,0,  31,mem_word(30),31,1,1, 1,0));
    // Run up through the top of memory and wrap to 0
    for (int a = 31; a <= 127; a++)
      prog.push_back(mk(1,0,0,0,0, (a+1)%128, mem_word(a), (a+1)%128, 1,1, 1,0));
    // Target truncated to AW bits
    prog.push_back(mk(1,0,0,1,32'h85, 5,0,0,0,3, 0,1));
    prog.push_back(mk(1,0,0,0,0,  5,0,0,0,1, 0,1));
    prog.push_back(mk(1,0,0,0,0,  6,mem_word(5),6,1,1, 1,0));
    // Branch, flush and stall together: branch wins; stall/flush ignored in REDIR
    prog.push_back(mk(1,1,1,1,2,  2,0,6,0,3, 0,1));
    prog.push_back(mk(1,1,1,0,0,  2,0,6,0,1, 0,1));
    for (int a = 2; a <= 5; a++)
      prog.push_back(mk(1,0,0,0,0, a+1, mem_word(a), a+1, 1,1, 1,0));
    // Reset arriving during HOLD
    prog.push_back(mk(1,1,0,0,0,  6,mem_word(5),6,1,2, 0,0));
    prog.push_back(mk(0,1,0,0,0,  0,0,0,0,0, 0,0));
    prog.push_back(mk(1,0,0,0,0,  0,0,0,0,1, 0,1));
    prog.push_back(mk(1,0,0,0,0,  1,32'hA000_00AA,1,1,1, 1,0));

    for (int i = 0; i < prog.size(); i++) begin
      exp_t e;
      @(negedge clk);
      rst_n         = prog[i].rst_n;
      stall         = prog[i].stall;
      flush         = prog[i].flush;
      branch_taken  = prog[i].br;
      branch_target = prog[i].tgt;
      if (!prog[i].rst_n) begin
        m_fcnt = '0;
        m_bcnt = '0;
      end else begin
        m_fcnt = m_fcnt + 32'(prog[i].df);
        m_bcnt = m_bcnt + 32'(prog[i].db);
      end
      e.pc = prog[i].pc; e.instr = prog[i].instr; e.npc = prog[i].npc;
      e.valid = prog[i].valid; e.st = prog[i].st;
`ifdef FETCH_PERF_CNT_EN
      e.fcnt = m_fcnt; e.bcnt = m_bcnt;
`else
      e.fcnt = '0; e.bcnt = '0;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", i, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("pc_addr",     i, pc_addr,            e.pc);
        chk("ifid_instr",  i, ifid_instr,         e.instr);
        chk("ifid_npc",    i, ifid_npc,           e.npc);
        chk("ifid_valid",  i, 32'(ifid_valid),    32'(e.valid));
        chk("fetch_state", i, 32'(fetch_state),   32'(e.st));
        chk("fetch_cnt",   i, fetch_cnt,          e.fcnt);
        chk("bubble_cnt",  i, bubble_cnt,         e.bcnt);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
